// File: rtl/axis_frame_tx_if.sv
// AXI-Stream bundle between a frame transmitter and its downstream sink.
//   tdata  : stream data word
//   tvalid : beat valid (source)
//   tlast  : final beat of a frame (source)
//   tready : sink can accept a beat
// master modport drives tdata/tvalid/tlast; slave modport drives tready.
interface axis_frame_tx_if #(
  parameter int unsigned DataWidth = 32
) ();
  logic [DataWidth-1:0] tdata;
  logic                 tvalid;
  logic                 tlast;
  logic                 tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_frame_tx.sv
// AXI-Stream frame transmitter. Words are pushed into an internal FIFO; a start
// pulse with a non-zero frame_len then emits exactly frame_len beats on m00_axis,
// with tlast on the final beat, honouring tready back-pressure.
//
// Ports:
//   aclk, areset        : clock, synchronous active-high reset
//   wr_data, wr_en      : FIFO push (accepted when not full)
//   fifo_full/empty     : FIFO occupancy flags
//   overflow            : sticky, set by a push while full
//   start, frame_len    : begin a frame of frame_len beats (ignored unless idle)
//   busy, done          : frame in progress / one-cycle completion pulse
//   stall_cnt           : stalled STREAM cycles (only with AXIS_TX_STALL_CNT_EN)
//   m00_axis            : AXI-Stream master
//
// Optional feature macro: AXIS_TX_STALL_CNT_EN adds the saturating stall_cnt output.
module axis_frame_tx #(
  parameter int unsigned M00_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH           = 16,
  parameter int unsigned LEN_WIDTH            = 16
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [M00_AXIS_TDATA_WIDTH-1:0] wr_data,
  input  logic                            wr_en,
  output logic                            fifo_full,
  output logic                            fifo_empty,
  output logic                            overflow,
  input  logic                            start,
  input  logic [LEN_WIDTH-1:0]            frame_len,
  output logic                            busy,
  output logic                            done,
`ifdef AXIS_TX_STALL_CNT_EN
  output logic [31:0]                     stall_cnt,
`endif
  axis_frame_tx_if.master                 m00_axis
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  logic [M00_AXIS_TDATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]                 count_q, count_d;
  logic                            overflow_q, overflow_d;
  state_e                          state_q, state_d;
  logic [LEN_WIDTH-1:0]            rem_q, rem_d;
  logic [M00_AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                            tvalid_q, tvalid_d;
  logic                            tlast_q, tlast_d;

  logic wr_accept, xfer, load, start_ok;

  always_comb begin
    fifo_full  = (count_q == CntW'(FIFO_DEPTH));
    fifo_empty = (count_q == '0);
    // Both flags come from the registered count, so a same-cycle read never
    // makes room for a write, and a fresh write is not readable until next cycle.
    wr_accept  = wr_en && !fifo_full;
    xfer       = tvalid_q && m00_axis.tready;
    // rem_q counts words still to be loaded into the output register.
    load       = (state_q == StStream) && (!tvalid_q || xfer) && !fifo_empty &&
                 (rem_q != '0);
    start_ok   = (state_q == StIdle) && start && (frame_len != '0);
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q || (wr_en && fifo_full);
    state_d    = state_q;
    rem_d      = rem_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;

    if (wr_accept) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (load)      rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({wr_accept, load})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    if (load) begin
      tdata_d  = mem_q[rd_ptr_q];
      tvalid_d = 1'b1;
      tlast_d  = (rem_q == LEN_WIDTH'(1));
      rem_d    = rem_q - LEN_WIDTH'(1);
    end else if (xfer) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          rem_d   = frame_len;
          state_d = StStream;
        end
      end
      StStream: if (xfer && tlast_q) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= StIdle;
      rem_q      <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      rem_q      <= rem_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
    end
  end

  // Storage needs no reset: the pointers and count fully define what is valid.
  always_ff @(posedge aclk) begin
    if (wr_accept) mem_q[wr_ptr_q] <= wr_data;
  end

`ifdef AXIS_TX_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (start_ok) begin
      stall_cnt_d = '0;
    end else if ((state_q == StStream) && tvalid_q && !m00_axis.tready &&
                 (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

  assign overflow        = overflow_q;
  assign busy            = (state_q == StStream);
  assign done            = (state_q == StDone);
  assign m00_axis.tdata  = tdata_q;
  assign m00_axis.tvalid = tvalid_q;
  assign m00_axis.tlast  = tlast_q;

endmodule

// File: doc/axis_frame_tx.md
Name: axis_frame_tx

Overview:
AXI-Stream frame transmitter: the master end that drives an s00_axis slave port, e.g. the acc_calc IP input, in system or testbench. Software/upstream pushes words into an internal FIFO, then issues a start with a frame length. The block emits exactly that many beats on m00_axis, with tlast on the final beat, and honours tready back-pressure.

Parameters:
M00_AXIS_TDATA_WIDTH, 32, width of m00_axis_tdata and wr_data
FIFO_DEPTH, 16, FIFO entries; power of two, >=2
LEN_WIDTH, 16, width of frame_len and internal beat counter

Ports:
aclk  in  1  clock; all logic on rising edge
areset  in  1  synchronous active-high reset
wr_data  in  M00_AXIS_TDATA_WIDTH  word to push into FIFO
wr_en  in  1  push strobe; accepted when !fifo_full
fifo_full  out  1  FIFO holds FIFO_DEPTH words
fifo_empty  out  1  FIFO holds 0 words
overflow  out  1  sticky; set by wr_en while fifo_full
start  in  1  one-cycle pulse; begins frame
frame_len  in  LEN_WIDTH  beats in frame; sampled on accepted start
busy  out  1  frame in progress
done  out  1  one-cycle pulse after tlast beat handshakes
m00_axis_tdata  out  M00_AXIS_TDATA_WIDTH  stream data
m00_axis_tvalid  out  1  stream valid
m00_axis_tlast  out  1  last beat of frame
m00_axis_tready  in  1  downstream ready

Behaviour:
- Reset (areset=1 at edge): FIFO pointers/count=0, fifo_empty=1, fifo_full=0, overflow=0, busy=0, done=0, tvalid=0, tlast=0, tdata=0, state=IDLE. Reset mid-frame aborts immediately; queued FIFO data discarded; no done.
- FIFO: registered count. Write accepted iff wr_en && !fifo_full, using count at start of cycle. A read in the same cycle does not free space for that write. Pointers wrap modulo FIFO_DEPTH. Write while full is dropped and sets overflow.
- Beat transfer: tvalid && tready at rising edge.
- States:
  - IDLE: busy=0. start && frame_len!=0 -> latch len, rem=len, go STREAM. start with frame_len==0 ignored, no done.
  - STREAM: busy=1. Output register loads the next FIFO word when it is empty or its beat transfers this cycle, and FIFO is non-empty and rem>0. tvalid rises the cycle after the load condition. tlast=1 exactly on beat rem==1.
  - STREAM exit: tlast beat transfers -> DONE.
  - DONE: done=1 for one cycle, busy=0, -> IDLE.
- start while busy or in DONE is ignored.
- Latency: start at edge N with FIFO non-empty -> tvalid=1 in cycle N+1. One beat per cycle sustained while tready=1 and FIFO non-empty.
- Hold rule: while tvalid && !tready, tdata, tvalid and tlast hold stable. tvalid never drops without a transfer.
- FIFO empty mid-frame: tvalid goes 0 after the current beat transfers and resumes the cycle after a new write. Frame stays open. No timeout.
- Simultaneous: wr_en and FIFO read in the same cycle both take effect; count unchanged. A write to an empty FIFO is visible for read the next cycle (no fall-through).
- FIFO words beyond len remain queued for the next frame.

Optional Feature:
AXIS_TX_STALL_CNT_EN: when defined, adds output stall_cnt [31:0].
- Increments each STREAM cycle with tvalid && !tready.
- Saturates at 0xFFFFFFFF.
- Clears on reset and on each accepted start.
When undefined, the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Push 0x1..0x4, start len=4, tready=1: beats 1,2,3,4 on consecutive cycles; tlast only on 0x4; done one cycle after; busy 0.
- Push 8 words, len=8, tready toggles 1,0,1,0: each word held stable across low-tready cycles; no word duplicated or skipped; 8 transfers total.
- len=3, push one word at a time with 2 idle cycles between pushes: tvalid gaps appear, frame ends after 3rd beat with tlast, done pulses once.
- Fill 16 words, push 17th: dropped, overflow=1 sticky; start len=16 outputs the original 16 words in order.
- Start with len=0: no tvalid, no done, busy stays 0. Start during busy: ignored; frame length unchanged.
- Mid-frame reset after 2 of 5 beats: next cycle tvalid=0, busy=0, fifo_empty=1; no done. AXIS_TX_STALL_CNT_EN: 3 stalled cycles give stall_cnt=3; next start clears it to 0.
